// File: rtl/fb_port_arbiter_if.sv
// fb_port_arbiter_if
//   Bundles the three buses around the framebuffer arbiter:
//     scanout read port  : rd_req, rd_addr -> rd_valid, rd_data, rd_drop
//     renderer write port: wr_valid, wr_addr, wr_data -> wr_ready
//     RAM command port   : ram_addr, ram_we, ram_wdata -> ram_rdata
//   modport slave  : the arbiter side
//   modport master : the clients/RAM side (scanout, renderer, RAM model)
interface fb_port_arbiter_if #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 4
);
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              rd_drop;
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport master (
    output rd_req, rd_addr, wr_valid, wr_addr, wr_data, ram_rdata,
    input  rd_valid, rd_data, rd_drop, wr_ready, ram_addr, ram_we, ram_wdata
  );

  modport slave (
    input  rd_req, rd_addr, wr_valid, wr_addr, wr_data, ram_rdata,
    output rd_valid, rd_data, rd_drop, wr_ready, ram_addr, ram_we, ram_wdata
  );
endinterface

// File: rtl/fb_port_arbiter.sv
// fb_port_arbiter
//   Shares the single-port framebuffer RAM between the VGA scanout (fixed
//   3-cycle read latency, strict priority) and the renderer (writes buffered
//   in a FIFO, drained into cycles with no scanout read).
//
// Ports:
//   pixel_clk    : pixel clock, all logic on its rising edge
//   rst_pixel_n  : asynchronous active-low reset
//   bus (slave)  : read port, write port and RAM command/data
//   fifo_level   : current write FIFO occupancy
//
// Configuration macro:
//   FB_ARB_STARVE_GUARD_EN : when defined, a write is forced into the RAM
//     after a full FIFO has been blocked by reads for STARVE_LIMIT cycles;
//     the read displaced in that cycle is reported through rd_drop.
//     When undefined, reads always win and rd_drop is tied low.
module fb_port_arbiter #(
  parameter int ADDR_W       = 19,
  parameter int DATA_W       = 4,
  parameter int FIFO_DEPTH   = 8,
  parameter int STARVE_LIMIT = 16
) (
  input  logic                         pixel_clk,
  input  logic                         rst_pixel_n,
  fb_port_arbiter_if.slave             bus,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(FIFO_DEPTH);

  // Write FIFO storage (data only, never reset) and control
  logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [LVL_W-1:0]  level;
  logic [LVL_W-1:0]  level_nxt;
  logic              wr_ready_r;

  logic fifo_empty;
  logic fifo_full;
  logic push;
  logic pop;
  logic grant_rd;
  logic force_wr;

  // RAM command and read result pipeline
  logic [ADDR_W-1:0] ram_addr_r;
  logic              ram_we_r;
  logic [DATA_W-1:0] ram_wdata_r;
  logic              vld_p1;
  logic              vld_p2;
  logic              vld_p3;
  logic [DATA_W-1:0] rd_data_p3;

  assign fifo_empty = (level == '0);
  assign fifo_full  = (level == DEPTH_L);

  // wr_ready already reflects occupancy after the previous edge, so a pop in
  // the same cycle never opens a slot for a push into a full FIFO.
  assign push      = bus.wr_valid && wr_ready_r;
  assign grant_rd  = bus.rd_req && !force_wr;
  assign pop       = force_wr || (!bus.rd_req && !fifo_empty);
  assign level_nxt = level + LVL_W'(push) - LVL_W'(pop);

`ifdef FB_ARB_STARVE_GUARD_EN
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [STV_W-1:0] STARVE_L = STV_W'(STARVE_LIMIT);

  logic [STV_W-1:0] starve_cnt;
  logic             drop_rd;
  logic             drop_p1;
  logic             drop_p2;
  logic             drop_p3;

  // The counter only advances while full, so reaching the limit implies a
  // head entry exists to force out.
  assign force_wr = (starve_cnt == STARVE_L) && !fifo_empty;
  assign drop_rd  = bus.rd_req && force_wr;

  always_ff @(posedge pixel_clk or negedge rst_pixel_n) begin
    if (!rst_pixel_n) begin
      starve_cnt <= '0;
    end else if (pop) begin
      starve_cnt <= '0;
    end else if (fifo_full && bus.rd_req && (starve_cnt != STARVE_L)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Drop flag travels alongside the read tag so it lands in the same slot
  always_ff @(posedge pixel_clk or negedge rst_pixel_n) begin
    if (!rst_pixel_n) begin
      drop_p1 <= 1'b0;
      drop_p2 <= 1'b0;
      drop_p3 <= 1'b0;
    end else begin
      drop_p1 <= drop_rd;
      drop_p2 <= drop_p1;
      drop_p3 <= drop_p2;
    end
  end

  assign bus.rd_drop = drop_p3;
`else
  assign force_wr    = 1'b0;
  assign bus.rd_drop = 1'b0;
`endif

  always_ff @(posedge pixel_clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= bus.wr_addr;
      fifo_data[wr_ptr] <= bus.wr_data;
    end
  end

  always_ff @(posedge pixel_clk or negedge rst_pixel_n) begin
    if (!rst_pixel_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      wr_ready_r <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      level      <= level_nxt;
      wr_ready_r <= (level_nxt < DEPTH_L);
    end
  end

  // Stage p1: RAM command register; read tag enters the result pipeline
  always_ff @(posedge pixel_clk or negedge rst_pixel_n) begin
    if (!rst_pixel_n) begin
      ram_addr_r  <= '0;
      ram_we_r    <= 1'b0;
      ram_wdata_r <= '0;
      vld_p1      <= 1'b0;
    end else begin
      vld_p1 <= grant_rd;
      if (pop) begin
        ram_addr_r  <= fifo_addr[rd_ptr];
        ram_wdata_r <= fifo_data[rd_ptr];
        ram_we_r    <= 1'b1;
      end else if (grant_rd) begin
        ram_addr_r <= bus.rd_addr;
        ram_we_r   <= 1'b0;
      end else begin
        ram_we_r   <= 1'b0;
      end
    end
  end

  // Stage p2: RAM is reading; p3: capture the RAM data for the tagged slot
  always_ff @(posedge pixel_clk or negedge rst_pixel_n) begin
    if (!rst_pixel_n) begin
      vld_p2     <= 1'b0;
      vld_p3     <= 1'b0;
      rd_data_p3 <= '0;
    end else begin
      vld_p2 <= vld_p1;
      vld_p3 <= vld_p2;
      if (vld_p2) rd_data_p3 <= bus.ram_rdata;
    end
  end

  assign bus.ram_addr  = ram_addr_r;
  assign bus.ram_we    = ram_we_r;
  assign bus.ram_wdata = ram_wdata_r;
  assign bus.rd_valid  = vld_p3;
  assign bus.rd_data   = rd_data_p3;
  assign bus.wr_ready  = wr_ready_r;
  assign fifo_level    = level;

endmodule

// File: tb/tb_fb_port_arbiter.sv
// tb_fb_port_arbiter
//   Scoreboard bench for fb_port_arbiter. A transaction-level reference model
//   (write queue, shadow memory, priority rule) predicts read results, RAM
//   write commands, FIFO level and wr_ready; a monitor on the falling edge
//   compares the DUT against those predictions. Includes a behavioural RAM.
`timescale 1ns/1ps
module tb_fb_port_arbiter;
  localparam int ADDR_W       = 19;
  localparam int DATA_W       = 4;
  localparam int FIFO_DEPTH   = 8;
  localparam int STARVE_LIMIT = 16;
`ifdef FB_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  typedef struct { int due; bit drop; logic [DATA_W-1:0] data; } rd_exp_t;
  typedef struct { int due; logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] data; } wr_exp_t;
  typedef struct { logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] data; } fifo_ent_t;

  logic pixel_clk   = 1'b0;
  logic rst_pixel_n = 1'b0;
  logic [$clog2(FIFO_DEPTH):0] fifo_level;

  fb_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  fb_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .FIFO_DEPTH(FIFO_DEPTH), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .pixel_clk(pixel_clk),
    .rst_pixel_n(rst_pixel_n),
    .bus(bus),
    .fifo_level(fifo_level)
  );

  always #5 pixel_clk = ~pixel_clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  rd_exp_t   rq[$];
  wr_exp_t   wq[$];
  fifo_ent_t fq[$];
  logic [DATA_W-1:0] ram_mem [int];
  logic [DATA_W-1:0] shadow  [int];
  fifo_ent_t pend;
  bit        pend_v  = 1'b0;
  bit        m_ready = 1'b0;
  int        starve  = 0;

  function automatic logic [DATA_W-1:0] init_val(logic [ADDR_W-1:0] a);
    return a[3:0] ^ a[11:8];
  endfunction

  function automatic logic [DATA_W-1:0] ram_get(logic [ADDR_W-1:0] a);
    if (ram_mem.exists(int'(a))) return ram_mem[int'(a)];
    return init_val(a);
  endfunction

  function automatic logic [DATA_W-1:0] shadow_get(logic [ADDR_W-1:0] a);
    if (shadow.exists(int'(a))) return shadow[int'(a)];
    return init_val(a);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Behavioural single-port RAM: synchronous read, write on ram_we
  always @(posedge pixel_clk) begin
    if (bus.ram_we) ram_mem[int'(bus.ram_addr)] = bus.ram_wdata;
    bus.ram_rdata <= ram_get(bus.ram_addr);
  end

  // Reference model: one decision per clock edge from the sampled inputs.
  // A granted write lands in memory one cycle later, so it is held pending
  // and committed at the next edge (or lost if reset intervenes).
  always @(posedge pixel_clk or negedge rst_pixel_n) begin
    if (!rst_pixel_n) begin
      rq.delete();
      wq.delete();
      fq.delete();
      pend_v  = 1'b0;
      m_ready = 1'b0;
      starve  = 0;
    end else begin
      bit        do_pop;
      bit        force_w;
      fifo_ent_t h;
      cyc++;
      if (pend_v) begin
        shadow[int'(pend.addr)] = pend.data;
        pend_v = 1'b0;
      end
      force_w = GUARD && (starve == STARVE_LIMIT);
      do_pop  = force_w || (!bus.rd_req && fq.size() > 0);
      if (bus.rd_req) begin
        if (force_w) rq.push_back('{cyc + 2, 1'b1, 4'h0});
        else         rq.push_back('{cyc + 2, 1'b0, shadow_get(bus.rd_addr)});
      end
      if (do_pop) begin
        h = fq.pop_front();
        pend   = h;
        pend_v = 1'b1;
        wq.push_back('{cyc, h.addr, h.data});
        starve = 0;
      end else if (bus.rd_req && fq.size() == FIFO_DEPTH) begin
        starve++;
      end
      if (bus.wr_valid && m_ready) fq.push_back('{bus.wr_addr, bus.wr_data});
      m_ready = (fq.size() < FIFO_DEPTH);
    end
  end

  // Monitor: compare every cycle, away from the active edge
  always @(negedge pixel_clk) begin
    bit ev;
    bit ed;
    bit ew;
    ev = 1'b0;
    ed = 1'b0;
    ew = 1'b0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      ev = !rq[0].drop;
      ed = rq[0].drop;
    end
    chk("rd_valid", 32'(bus.rd_valid), 32'(ev));
    chk("rd_drop", 32'(bus.rd_drop), 32'(ed));
    if (ev && bus.rd_valid) chk("rd_data", 32'(bus.rd_data), 32'(rq[0].data));
    if (rq.size() > 0 && rq[0].due <= cyc) rq.delete(0);

    if (wq.size() > 0 && wq[0].due == cyc) ew = 1'b1;
    chk("ram_we", 32'(bus.ram_we), 32'(ew));
    if (ew && bus.ram_we) begin
      chk("ram_addr", 32'(bus.ram_addr), 32'(wq[0].addr));
      chk("ram_wdata", 32'(bus.ram_wdata), 32'(wq[0].data));
    end
    if (wq.size() > 0 && wq[0].due <= cyc) wq.delete(0);

    chk("fifo_level", 32'(fifo_level), 32'(fq.size()));
    chk("wr_ready", 32'(bus.wr_ready), 32'(m_ready));
  end

  task automatic tick();
    @(posedge pixel_clk);
    #1;
  endtask

  function automatic logic [ADDR_W-1:0] rand_addr();
    if ($urandom % 2 == 0) return ADDR_W'($urandom_range(0, 15));
    return ADDR_W'($urandom);
  endfunction

  task automatic drain(input string nm);
    bus.rd_req   = 1'b0;
    bus.wr_valid = 1'b0;
    for (int k = 0; k < 200 && fifo_level != 0; k++) tick();
    repeat (4) tick();
    chk(nm, 32'(fifo_level), 32'd0);
  endtask

  initial begin
    bus.rd_req   = 1'b0;
    bus.rd_addr  = '0;
    bus.wr_valid = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    ram_mem[16]  = 4'hA;
    shadow[16]   = 4'hA;

    // Reset values
    @(posedge pixel_clk);
    #2;
    chk("rst ram_we", 32'(bus.ram_we), 32'd0);
    chk("rst ram_addr", 32'(bus.ram_addr), 32'd0);
    chk("rst ram_wdata", 32'(bus.ram_wdata), 32'd0);
    chk("rst rd_valid", 32'(bus.rd_valid), 32'd0);
    chk("rst rd_data", 32'(bus.rd_data), 32'd0);
    chk("rst rd_drop", 32'(bus.rd_drop), 32'd0);
    chk("rst wr_ready", 32'(bus.wr_ready), 32'd0);
    chk("rst fifo_level", 32'(fifo_level), 32'd0);
    @(negedge pixel_clk);
    rst_pixel_n = 1'b1;
    #1;
    chk("wr_ready before first edge", 32'(bus.wr_ready), 32'd0);
    tick();

    // First read from preloaded location
    bus.rd_req  = 1'b1;
    bus.rd_addr = 19'h00010;
    tick();
    bus.rd_req = 1'b0;
    repeat (4) tick();

    // Single write in idle time, then read it back
    bus.wr_valid = 1'b1;
    bus.wr_addr  = 19'h12345;
    bus.wr_data  = 4'h7;
    tick();
    bus.wr_valid = 1'b0;
    repeat (3) tick();
    bus.rd_req  = 1'b1;
    bus.rd_addr = 19'h12345;
    tick();
    bus.rd_req = 1'b0;
    repeat (4) tick();

    // Fill the FIFO under continuous reads, then release
    bus.rd_req = 1'b1;
    for (int i = 0; i < 9; i++) begin
      bus.rd_addr  = rand_addr();
      bus.wr_valid = 1'b1;
      bus.wr_addr  = rand_addr();
      bus.wr_data  = DATA_W'($urandom);
      tick();
    end
    bus.wr_valid = 1'b0;
    tick();
    chk("full fifo_level", 32'(fifo_level), 32'd8);
    chk("full wr_ready", 32'(bus.wr_ready), 32'd0);
    bus.rd_req = 1'b0;
    repeat (10) tick();
    chk("drained wr_ready", 32'(bus.wr_ready), 32'd1);
    chk("drained fifo_level", 32'(fifo_level), 32'd0);

    // Occupancy 3, then simultaneous push/pop pairs across pointer wrap
    bus.rd_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.rd_addr  = rand_addr();
      bus.wr_valid = 1'b1;
      bus.wr_addr  = rand_addr();
      bus.wr_data  = DATA_W'($urandom);
      tick();
    end
    bus.rd_req = 1'b0;
    for (int i = 0; i < 20; i++) begin
      bus.wr_addr = rand_addr();
      bus.wr_data = DATA_W'($urandom);
      tick();
      if (i == 0) chk("push+pop fifo_level", 32'(fifo_level), 32'd3);
    end
    drain("drain after wrap");

    // Randomised traffic: active lines (mostly reads) and blanking
    for (int i = 0; i < 3000; i++) begin
      if (((i / 100) % 3) != 0) bus.rd_req = ($urandom % 10) != 0;
      else                      bus.rd_req = ($urandom % 4) == 0;
      bus.rd_addr  = rand_addr();
      bus.wr_valid = $urandom % 2;
      bus.wr_addr  = rand_addr();
      bus.wr_data  = DATA_W'($urandom);
      tick();
    end
    drain("drain after random");

`ifdef FB_ARB_STARVE_GUARD_EN
    // Long read burst with a full FIFO forces writes through
    bus.rd_req = 1'b1;
    for (int i = 0; i < 70; i++) begin
      bus.rd_addr  = rand_addr();
      bus.wr_valid = (i < 40);
      bus.wr_addr  = rand_addr();
      bus.wr_data  = DATA_W'($urandom);
      tick();
    end
    drain("drain after starve");
`endif

    // Reset with 4 queued writes and reads in flight
    bus.rd_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.rd_addr  = rand_addr();
      bus.wr_valid = 1'b1;
      bus.wr_addr  = rand_addr();
      bus.wr_data  = DATA_W'($urandom);
      tick();
    end
    chk("pre-reset fifo_level", 32'(fifo_level), 32'd4);
    #1;
    rst_pixel_n = 1'b0;
    #1;
    chk("async rst ram_we", 32'(bus.ram_we), 32'd0);
    chk("async rst rd_valid", 32'(bus.rd_valid), 32'd0);
    chk("async rst fifo_level", 32'(fifo_level), 32'd0);
    bus.rd_req   = 1'b0;
    bus.wr_valid = 1'b0;
    repeat (2) @(posedge pixel_clk);
    @(negedge pixel_clk);
    rst_pixel_n = 1'b1;
    repeat (10) tick();

    // A short burst after reset
    for (int i = 0; i < 200; i++) begin
      bus.rd_req   = ($urandom % 3) == 0;
      bus.rd_addr  = rand_addr();
      bus.wr_valid = $urandom % 2;
      bus.wr_addr  = rand_addr();
      bus.wr_data  = DATA_W'($urandom);
      tick();
    end
    drain("final drain");
    chk("outstanding expectations", 32'(rq.size() + wq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fb_port_arbiter.md
# fb_port_arbiter

Shares the single-port 4-bit-per-pixel framebuffer RAM between two clients. The VGA scanout read port has fixed latency and strict priority; a renderer write port is buffered through a small FIFO and drains into free RAM cycles. The block sits between the VGA driver's colour lookup (`addr`/`data`) and the framebuffer RAM, all in the pixel clock domain.

## Interface
Parameters:
- `ADDR_W`, 19, framebuffer address width
- `DATA_W`, 4, pixel (palette index) width
- `FIFO_DEPTH`, 8, write FIFO entries; power of two, ≥2
- `STARVE_LIMIT`, 16, cycles a full FIFO may be blocked before a forced write slot (used only with `FB_ARB_STARVE_GUARD_EN`)

Ports:
- `pixel_clk` in 1: single clock; all logic on its rising edge
- `rst_pixel_n` in 1: reset, asynchronous, active-low
- `rd_req` in 1: scanout read request this cycle
- `rd_addr` in ADDR_W: scanout address
- `rd_valid` out 1: `rd_data` valid
- `rd_data` out DATA_W: pixel read
- `rd_drop` out 1: the read in this result slot was dropped by the starve guard
- `wr_valid` in 1: renderer write offered
- `wr_ready` out 1: FIFO accepts this cycle
- `wr_addr` in ADDR_W, `wr_data` in DATA_W: write payload
- `ram_addr` out ADDR_W, `ram_we` out 1, `ram_wdata` out DATA_W: RAM command (registered)
- `ram_rdata` in DATA_W: RAM synchronous read data, one cycle after the command
- `fifo_level` out $clog2(FIFO_DEPTH)+1: current FIFO occupancy

## Operation
- Write FIFO: push on `wr_valid && wr_ready`. `wr_ready` is registered: it is high when occupancy after this edge is < FIFO_DEPTH. No push while full, even if a pop occurs in the same cycle.
- Arbitration (per cycle, N): if `rd_req`, grant read. Else if FIFO is non-empty, grant write (pop head). Else idle.
- Grant read: `ram_addr<=rd_addr`, `ram_we<=0`, and a read tag enters the 2-stage result pipeline.
- Grant write: `ram_addr/ram_wdata<=head`, `ram_we<=1`.
- Idle: `ram_we<=0`. `ram_addr` and `ram_wdata` hold their values.
- Result pipeline: tag stage 1 → stage 2. At stage 2, `rd_data<=ram_rdata`, and `rd_valid` takes the tag.
- A simultaneous push and pop leaves occupancy unchanged. Pointers wrap modulo FIFO_DEPTH.
- Read/write to the same address in adjacent cycles: the RAM order decides, with no forwarding. A read granted in the cycle after a write returns the new data.
- Reset (async assert, at any time, including mid-operation): the FIFO is flushed, pending read tags are discarded, and the guard counter is cleared.
- Reset values: `ram_we=0`, `ram_addr=0`, `ram_wdata=0`, `rd_valid=0`, `rd_data=0`, `rd_drop=0`, `wr_ready=0`, `fifo_level=0`. `wr_ready` rises at the first edge after deassertion.

## Timing
- Read latency is 3 cycles. A `rd_req` sampled in cycle N gives `ram_addr` in N+1, `ram_rdata` in N+2, and `rd_valid`/`rd_data` in N+3.
- Back-to-back reads sustain 1 result per cycle.
- Write latency is at least 2 cycles: pushed in N, earliest `ram_we` is in N+2 (popped in N+1 if the FIFO was empty and `rd_req` is low).
- Write throughput equals the number of idle read cycles (blanking intervals).
- `wr_ready` deasserts one cycle after the push that fills the FIFO. It reasserts one cycle after the first pop from full.

## Configuration
- `FB_ARB_STARVE_GUARD_EN` defined:
  - A counter increments each cycle the FIFO is full and `rd_req` blocks the pop. It is cleared on any pop.
  - When the counter equals STARVE_LIMIT, the next cycle grants a write regardless of `rd_req`.
  - That read is dropped: its result slot (N+3) has `rd_valid=0` and `rd_drop=1`.
- Not defined:
  - Reads always win.
  - `rd_drop` is tied to 0.
  - The counter is not instantiated.

## Test plan
- Reset, then `rd_req` with `rd_addr=0x00010` and RAM model holding 0xA → `rd_valid=1`, `rd_data=0xA` exactly 3 cycles later. Before that, all outputs equal their reset values.
- `rd_req=0`, push (0x12345, 0x7) → `ram_we=1`, `ram_addr=0x12345`, `ram_wdata=0x7` 2 cycles after the push. A subsequent read of 0x12345 returns 0x7.
- `rd_req` held high, 9 pushes with FIFO_DEPTH=8 → `wr_ready` falls after the 8th push and `fifo_level=8`. Drop `rd_req` → 8 writes in FIFO order, then `wr_ready=1`.
- Push during a pop at occupancy 3 → `fifo_level` stays 3. Pointer wrap after 20 push/pop pairs preserves data order.
- With `FB_ARB_STARVE_GUARD_EN`, FIFO full and `rd_req` high for 16 cycles → one forced write. `rd_drop=1` with `rd_valid=0` 3 cycles after the dropped request. All other reads are unaffected.
- Assert `rst_pixel_n=0` with 4 FIFO entries and 2 reads in flight → `ram_we`, `rd_valid` and `fifo_level` go to 0 immediately. After release, no stale writes or results appear.
